// File: rtl/div_pkg.sv
// Shared types for the restoring-divider pipeline.
// Holds default widths, stage-state encoding and the entry bundle.
package div_pkg;

  localparam int DIVISOR_BITS_DEF  = 8;
  localparam int DIVIDEND_BITS_DEF = 16;
  localparam int TAG_BITS_DEF      = 4;

  function automatic int add_bits(
    input int dvs,
    input int dvd
  );
    return dvs + dvd - 1;
  endfunction

  localparam int ADD_BITS_DEF =
    add_bits(DIVISOR_BITS_DEF, DIVIDEND_BITS_DEF);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  typedef struct packed {
    logic [ADD_BITS_DEF-1:0]      dividend;
    logic [ADD_BITS_DEF-1:0]      divisor;
    logic [DIVIDEND_BITS_DEF-1:0] quotient;
    logic [TAG_BITS_DEF-1:0]      tag;
  } div_entry_t;

  function automatic logic [1:0] occ_of(
    input stage_state_e s
  );
    logic [1:0] n;
    n = 2'd0;
    case (s)
      ST_ONE:  n = 2'd1;
      ST_TWO:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/div_stage_reg.sv
// Flow-controlled register between two divider iterations.
// SKID=1 gives a two-entry buffer with registered in_ready.
module div_stage_reg
  import div_pkg::*;
#(
  parameter int DIVISOR_BITS  = DIVISOR_BITS_DEF,
  parameter int DIVIDEND_BITS = DIVIDEND_BITS_DEF,
  parameter int ADD_BITS      =
    add_bits(DIVISOR_BITS, DIVIDEND_BITS),
  parameter int TAG_BITS      = TAG_BITS_DEF,
  parameter bit SKID          = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADD_BITS-1:0]      in_dividend,
  input  logic [ADD_BITS-1:0]      in_divisor,
  input  logic [DIVIDEND_BITS-1:0] in_quotient,
  input  logic [TAG_BITS-1:0]      in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADD_BITS-1:0]      out_dividend,
  output logic [ADD_BITS-1:0]      out_divisor,
  output logic [DIVIDEND_BITS-1:0] out_quotient,
  output logic [TAG_BITS-1:0]      out_tag,
  output logic [1:0]               occupancy
);

  typedef struct packed {
    logic [ADD_BITS-1:0]      dividend;
    logic [ADD_BITS-1:0]      divisor;
    logic [DIVIDEND_BITS-1:0] quotient;
    logic [TAG_BITS-1:0]      tag;
  } entry_t;

  entry_t in_e;
  entry_t head;

  assign in_e = '{
    dividend: in_dividend,
    divisor:  in_divisor,
    quotient: in_quotient,
    tag:      in_tag
  };

  assign out_dividend = head.dividend;
  assign out_divisor  = head.divisor;
  assign out_quotient = head.quotient;
  assign out_tag      = head.tag;

  if (SKID) begin : g_skid
    stage_state_e state_q, state_d;
    entry_t       main_q, main_d;
    entry_t       skid_q, skid_d;
    logic         rdy_q, rdy_d;
    logic [1:0]   occ_q, occ_d;
    logic         acc, pop, vld;

    assign vld = state_q != ST_EMPTY;
    // Flush drops the presented entry even when ready.
    assign acc = in_valid & rdy_q & ~flush;
    assign pop = vld & out_ready;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        ST_EMPTY:
          if (acc) begin
            state_d = ST_ONE;
            main_d  = in_e;
          end
        ST_ONE:
          if (acc && pop) begin
            main_d = in_e;
          end else if (acc) begin
            state_d = ST_TWO;
            skid_d  = in_e;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        ST_TWO:
          if (pop) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        default: state_d = ST_EMPTY;
      endcase
      if (flush) state_d = ST_EMPTY;
      rdy_d = state_d != ST_TWO;
      occ_d = occ_of(state_d);
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= ST_EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
        rdy_q   <= 1'b0;
        occ_q   <= 2'd0;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        rdy_q   <= rdy_d;
        occ_q   <= occ_d;
      end
    end

    assign in_ready  = rdy_q & ~reset;
    assign out_valid = vld;
    assign occupancy = occ_q;
    assign head      = main_q;
  end else begin : g_flop
    entry_t main_q, main_d;
    logic   valid_q, valid_d;
    logic   rdy, acc, pop;

    assign rdy = ~reset & (~valid_q | out_ready);
    assign acc = in_valid & rdy & ~flush;
    assign pop = valid_q & out_ready;

    always_comb begin
      main_d  = main_q;
      valid_d = valid_q;
      if (acc) begin
        main_d  = in_e;
        valid_d = 1'b1;
      end else if (pop) begin
        valid_d = 1'b0;
      end
      if (flush) valid_d = 1'b0;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        main_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        main_q  <= main_d;
        valid_q <= valid_d;
      end
    end

    assign in_ready  = rdy;
    assign out_valid = valid_q;
    assign occupancy = {1'b0, valid_q};
    assign head      = main_q;
  end

endmodule
